// File: rtl/tpg_frame_sched.sv
// -----------------------------------------------------------------------------
// tpg_frame_sched
//
// Frame scheduler / stream sequencer for the incrementing test-pattern
// generator. While `enable` is seen high at a frame boundary it emits one
// frame on a valid/ready stream. Each frame is made up of:
//   * a 3-beat control packet: 0x00000F (sop), width, height (eop)
//   * a video packet: header beat 0x000000 (sop), then WIDTH*HEIGHT pixel
//     beats carrying {y[11:0], x[11:0]}, with eop on the last pixel
//   * GAP idle cycles with dout_valid low
//
// Parameters
//   WIDTH  active pixels per line   (1..65535)
//   HEIGHT active lines per frame   (1..65535)
//   GAP    idle cycles after each video packet (0..65535, 0 = none)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   enable       run request, sampled only at frame boundaries
//   dout_ready   sink ready
//   dout_valid   beat valid
//   dout_data    24-bit beat payload
//   dout_sop     first beat of a packet
//   dout_eop     last beat of a packet
//   busy         high whenever the scheduler is not idle
//   frame_done   one-cycle pulse after the video eop beat transfers
//   frame_count  completed frames, wraps 65535 -> 0
//
// The output beat (valid/data/sop/eop) lives in registers. The next beat is
// computed combinationally from the current state whenever the current beat
// transfers, so a continuously ready sink takes one beat per cycle across
// every packet boundary.
// -----------------------------------------------------------------------------
module tpg_frame_sched #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int GAP    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dout_ready,
  output logic        dout_valid,
  output logic [23:0] dout_data,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CTRL = 3'd1;
  localparam logic [2:0] S_VHDR = 3'd2;
  localparam logic [2:0] S_VID  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
  // Only meaningful when GAP > 0; the GAP state is never entered otherwise.
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam bit          HAS_GAP  = (GAP != 0);

  localparam logic [23:0] CTRL_ID  = 24'h00000F;
  localparam logic [23:0] CTRL_W   = {8'h00, 16'(WIDTH)};
  localparam logic [23:0] CTRL_H   = {8'h00, 16'(HEIGHT)};
  localparam logic [23:0] VHDR_ID  = 24'h000000;

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [1:0]  ctrl_idx_q, ctrl_idx_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        valid_q, valid_d;
  logic [23:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        xfer;
  logic        boundary;
  logic [15:0] x_n;
  logic [15:0] y_n;

  // True when (x, y) addresses the final pixel of the frame.
  function automatic logic is_last_pixel(input logic [15:0] x, input logic [15:0] y);
    return (x == X_LAST) && (y == Y_LAST);
  endfunction

  assign xfer = valid_q && dout_ready;

  // ---------------------------------------------------------------------------
  // Next-state / next-beat logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ctrl_idx_d = ctrl_idx_q;
    x_d        = x_q;
    y_d        = y_q;
    gap_d      = gap_q;
    fcnt_d     = fcnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    done_d     = 1'b0;
    boundary   = 1'b0;
    x_n        = x_q;
    y_n        = y_q;

    case (state_q)
      // IDLE behaves exactly like a frame boundary: start on enable, else stay.
      S_IDLE: boundary = 1'b1;

      S_CTRL: begin
        if (xfer) begin
          case (ctrl_idx_q)
            2'd0: begin
              ctrl_idx_d = 2'd1;
              data_d     = CTRL_W;
              sop_d      = 1'b0;
              eop_d      = 1'b0;
            end
            2'd1: begin
              ctrl_idx_d = 2'd2;
              data_d     = CTRL_H;
              sop_d      = 1'b0;
              eop_d      = 1'b1;
            end
            default: begin
              ctrl_idx_d = 2'd0;
              state_d    = S_VHDR;
              data_d     = VHDR_ID;
              sop_d      = 1'b1;
              eop_d      = 1'b0;
            end
          endcase
        end
      end

      S_VHDR: begin
        // The first pixel (0,0) is already the last one for a 1x1 frame.
        if (xfer) begin
          state_d = S_VID;
          x_d     = 16'd0;
          y_d     = 16'd0;
          data_d  = 24'h000000;
          sop_d   = 1'b0;
          eop_d   = is_last_pixel(16'd0, 16'd0);
        end
      end

      S_VID: begin
        if (xfer) begin
          if (eop_q) begin
            // Final pixel of the frame has just been accepted.
            x_d    = 16'd0;
            y_d    = 16'd0;
            fcnt_d = fcnt_q + 16'd1;
            done_d = 1'b1;
            if (HAS_GAP) begin
              state_d = S_GAP;
              gap_d   = 16'd0;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
            end else begin
              boundary = 1'b1;
            end
          end else begin
            if (x_q == X_LAST) begin
              x_n = 16'd0;
              y_n = y_q + 16'd1;
            end else begin
              x_n = x_q + 16'd1;
            end
            x_d    = x_n;
            y_d    = y_n;
            data_d = {y_n[11:0], x_n[11:0]};
            sop_d  = 1'b0;
            eop_d  = is_last_pixel(x_n, y_n);
          end
        end
      end

      S_GAP: begin
        // gap_q counts 0..GAP-1, one idle cycle per value.
        if (gap_q == GAP_LAST) begin
          boundary = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
    endcase

    // Frame boundary: either present control beat 0 right away, or go idle.
    if (boundary) begin
      gap_d      = 16'd0;
      ctrl_idx_d = 2'd0;
      if (enable) begin
        state_d = S_CTRL;
        valid_d = 1'b1;
        data_d  = CTRL_ID;
        sop_d   = 1'b1;
        eop_d   = 1'b0;
      end else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_idx_q <= 2'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      gap_q      <= 16'd0;
      fcnt_q     <= 16'd0;
      valid_q    <= 1'b0;
      data_q     <= 24'd0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_idx_q <= ctrl_idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      gap_q      <= gap_d;
      fcnt_q     <= fcnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout_valid  = valid_q;
  assign dout_data   = data_q;
  assign dout_sop    = sop_q;
  assign dout_eop    = eop_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_tpg_frame_sched.sv
// -----------------------------------------------------------------------------
// Bench for tpg_frame_sched. Three instances cover the parameter sets:
//   0: WIDTH=4 HEIGHT=2 GAP=3   basic, back-pressure, enable drop, reset
//   1: WIDTH=4 HEIGHT=2 GAP=0   back-to-back frames
//   2: WIDTH=1 HEIGHT=1 GAP=3   degenerate size
// Expected beats come from frame tables and go through one shared scoreboard
// queue tagged with the instance id; a negedge monitor pops and compares on
// every transfer and checks that stalled beats hold.
// -----------------------------------------------------------------------------
module tb_tpg_frame_sched;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic        e;
  } beat_t;

  typedef struct {
    int          id;
    logic [23:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst_v [3];
  logic        en    [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic [23:0] dat   [3];
  logic        sop   [3];
  logic        eop   [3];
  logic        bsy   [3];
  logic        fdn   [3];
  logic [15:0] fcnt  [3];

  beat_t frame_a [12];
  beat_t frame_c [5];
  exp_t  exp_q [$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fd_cnt [3];

  logic        held  [3];
  logic [25:0] hbeat [3];

  tpg_frame_sched #(.WIDTH(4), .HEIGHT(2), .GAP(3)) u_a (
    .clk(clk), .rst(rst_v[0]), .enable(en[0]), .dout_ready(rdy[0]),
    .dout_valid(vld[0]), .dout_data(dat[0]), .dout_sop(sop[0]), .dout_eop(eop[0]),
    .busy(bsy[0]), .frame_done(fdn[0]), .frame_count(fcnt[0]));

  tpg_frame_sched #(.WIDTH(4), .HEIGHT(2), .GAP(0)) u_b (
    .clk(clk), .rst(rst_v[1]), .enable(en[1]), .dout_ready(rdy[1]),
    .dout_valid(vld[1]), .dout_data(dat[1]), .dout_sop(sop[1]), .dout_eop(eop[1]),
    .busy(bsy[1]), .frame_done(fdn[1]), .frame_count(fcnt[1]));

  tpg_frame_sched #(.WIDTH(1), .HEIGHT(1), .GAP(3)) u_c (
    .clk(clk), .rst(rst_v[2]), .enable(en[2]), .dout_ready(rdy[2]),
    .dout_valid(vld[2]), .dout_data(dat[2]), .dout_sop(sop[2]), .dout_eop(eop[2]),
    .busy(bsy[2]), .frame_done(fdn[2]), .frame_count(fcnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_frame(input int id);
    if (id == 2) begin
      for (int i = 0; i < 5; i++) exp_q.push_back('{id, frame_c[i].d, frame_c[i].s, frame_c[i].e});
    end else begin
      for (int i = 0; i < 12; i++) exp_q.push_back('{id, frame_a[i].d, frame_a[i].s, frame_a[i].e});
    end
  endtask

  // Waits (bounded) for a transfer of the given beat on instance id.
  task automatic wait_beat(input int id, input logic [23:0] d, input logic s,
                           input logic e, input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (vld[id] && rdy[id] && !rst_v[id] && dat[id] == d && sop[id] == s && eop[id] == e)
        found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for beat 0x%06h sop=%0d eop=%0d", nm, d, s, e);
    end
  endtask

  // Scoreboard monitor: transfers are decided by values seen at the negedge,
  // which stay put until the following rising edge.
  initial begin
    for (int i = 0; i < 3; i++) begin
      held[i]   = 1'b0;
      hbeat[i]  = '0;
      fd_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (held[i] && !rst_v[i])
          chk($sformatf("hold%0d", i), {vld[i], sop[i], eop[i], dat[i]}, {1'b1, hbeat[i]});
        held[i]  = vld[i] && !rdy[i] && !rst_v[i];
        hbeat[i] = {sop[i], eop[i], dat[i]};
        if (vld[i] && rdy[i] && !rst_v[i]) begin
          if (exp_q.size() == 0 || exp_q[0].id != i) begin
            checks++;
            errors++;
            $display("FAIL beat%0d: unexpected beat 0x%06h sop=%0d eop=%0d, none required",
                     i, dat[i], sop[i], eop[i]);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk($sformatf("beat%0d", i), {sop[i], eop[i], dat[i]}, {x.s, x.e, x.d});
          end
        end
        if (fdn[i] && !rst_v[i]) fd_cnt[i]++;
      end
    end
  end

  initial begin
    int t1, t2, t3;
    logic pat [4];

    frame_a[0]  = '{24'h00000F, 1'b1, 1'b0};
    frame_a[1]  = '{24'h000004, 1'b0, 1'b0};
    frame_a[2]  = '{24'h000002, 1'b0, 1'b1};
    frame_a[3]  = '{24'h000000, 1'b1, 1'b0};
    frame_a[4]  = '{24'h000000, 1'b0, 1'b0};
    frame_a[5]  = '{24'h000001, 1'b0, 1'b0};
    frame_a[6]  = '{24'h000002, 1'b0, 1'b0};
    frame_a[7]  = '{24'h000003, 1'b0, 1'b0};
    frame_a[8]  = '{24'h001000, 1'b0, 1'b0};
    frame_a[9]  = '{24'h001001, 1'b0, 1'b0};
    frame_a[10] = '{24'h001002, 1'b0, 1'b0};
    frame_a[11] = '{24'h001003, 1'b0, 1'b1};
    frame_c[0]  = '{24'h00000F, 1'b1, 1'b0};
    frame_c[1]  = '{24'h000001, 1'b0, 1'b0};
    frame_c[2]  = '{24'h000001, 1'b0, 1'b1};
    frame_c[3]  = '{24'h000000, 1'b1, 1'b0};
    frame_c[4]  = '{24'h000000, 1'b0, 1'b1};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      en[i]    = 1'b0;
      rdy[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_state%0d", i),
          {vld[i], sop[i], eop[i], bsy[i], fdn[i], dat[i], fcnt[i]}, 64'd0);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    // ---- basic frame, gap timing, enable drop mid-frame ----
    push_frame(0);
    push_frame(0);
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    wait_beat(0, 24'h00000F, 1'b1, 1'b0, "a_sop1");
    t1 = cyc;
    wait_beat(0, 24'h001003, 1'b0, 1'b1, "a_eop1");
    t2 = cyc;
    wait_beat(0, 24'h00000F, 1'b1, 1'b0, "a_sop2");
    t3 = cyc;
    // eop cycle, 3 idle cycles, then the next sop
    chk("a_eop_to_sop", 64'(t3 - t2), 64'd4);
    chk("a_frame_period", 64'(t3 - t1), 64'd15);
    wait_beat(0, 24'h000002, 1'b0, 1'b0, "a_pix2");
    en[0] = 1'b0;
    wait_beat(0, 24'h001003, 1'b0, 1'b1, "a_eop2");
    @(negedge clk);
    chk("a_done_pulse", {fdn[0], bsy[0], vld[0]}, 3'b110);
    @(negedge clk);
    chk("a_done_clear", fdn[0], 1'b0);
    @(negedge clk);
    chk("a_gap_busy", {bsy[0], vld[0]}, 2'b10);
    @(negedge clk);
    chk("a_idle_after_gap", {bsy[0], vld[0]}, 2'b00);
    chk("a_frame_count", fcnt[0], 16'd2);
    chk("a_done_count", 64'(fd_cnt[0]), 64'd2);

    // ---- back-pressure: ready 1,0,0,1 repeating ----
    push_frame(0);
    @(posedge clk); #1;
    en[0] = 1'b1;
    @(posedge clk); #1;
    en[0] = 1'b0;
    for (int k = 0; k < 200 && fd_cnt[0] < 3; k++) begin
      rdy[0] = pat[k % 4];
      @(posedge clk); #1;
    end
    rdy[0] = 1'b1;
    chk("bp_done_count", 64'(fd_cnt[0]), 64'd3);
    chk("bp_frame_count", fcnt[0], 16'd3);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_idle", {bsy[0], vld[0]}, 2'b00);

    // ---- reset during the video packet ----
    push_frame(0);
    en[0] = 1'b1;
    wait_beat(0, 24'h001000, 1'b0, 1'b0, "r_pix");
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("r_outputs_cleared",
        {vld[0], sop[0], eop[0], bsy[0], fdn[0], dat[0], fcnt[0]}, 64'd0);
    exp_q.delete();
    push_frame(0);
    rst_v[0] = 1'b0;
    wait_beat(0, 24'h00000F, 1'b1, 1'b0, "r_restart");
    chk("r_count_restart", fcnt[0], 16'd0);
    en[0] = 1'b0;
    wait_beat(0, 24'h001003, 1'b0, 1'b1, "r_eop");
    repeat (6) @(negedge clk);
    chk("r_frame_count", fcnt[0], 16'd1);
    chk("r_idle", bsy[0], 1'b0);

    // ---- GAP = 0 back-to-back frames ----
    push_frame(1);
    push_frame(1);
    push_frame(1);
    rdy[1] = 1'b1;
    en[1]  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_beat(1, 24'h001003, 1'b0, 1'b1, "b_eop");
      @(negedge clk);
      if (f < 2) begin
        chk("b_next_sop", {vld[1], sop[1], eop[1], dat[1]}, {3'b110, 24'h00000F});
        chk("b_frame_count", fcnt[1], 16'(f + 1));
        if (f == 1) en[1] = 1'b0;
      end else begin
        chk("b_idle", {vld[1], bsy[1], fdn[1]}, 3'b001);
        chk("b_frame_count_final", fcnt[1], 16'd3);
      end
    end

    // ---- degenerate 1x1 frame ----
    push_frame(2);
    rdy[2] = 1'b1;
    @(posedge clk); #1;
    en[2] = 1'b1;
    @(posedge clk); #1;
    en[2] = 1'b0;
    wait_beat(2, 24'h000000, 1'b0, 1'b1, "c_pix");
    @(negedge clk);
    chk("c_done", {fdn[2], fcnt[2]}, {1'b1, 16'd1});
    repeat (5) @(negedge clk);
    chk("c_idle", {bsy[2], vld[2]}, 2'b00);

    chk("all_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
